// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic, shift-add MUL and restoring DIV, valid/ready on both sides.
// Optional build macro ALU_SATURATE_EN clamps ADD/SUB/MUL overflow instead of wrapping.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag,
    output logic             dbz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    // Each returns {flag, result}; the flag always reports the overflow condition.
    function automatic logic [WIDTH:0] sat_add(input logic [WIDTH:0] sum);
`ifdef ALU_SATURATE_EN
        return sum[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : sum;
`else
        return sum;
`endif
    endfunction

    function automatic logic [WIDTH:0] sat_sub(input logic [WIDTH:0] diff);
`ifdef ALU_SATURATE_EN
        return diff[WIDTH] ? {1'b1, {WIDTH{1'b0}}} : diff;
`else
        return diff;
`endif
    endfunction

    function automatic logic [WIDTH:0] sat_mul(input logic [2*WIDTH-1:0] prod);
        logic ovf;
        ovf = |prod[2*WIDTH-1:WIDTH];
`ifdef ALU_SATURATE_EN
        return ovf ? {1'b1, {WIDTH{1'b1}}} : {1'b0, prod[WIDTH-1:0]};
`else
        return {ovf, prod[WIDTH-1:0]};
`endif
    endfunction

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_out;
    logic               r_flag;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_res;
    logic               w_flg;
    logic               w_dbz;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic               w_last;

    always_comb begin
        w_res = '0;
        w_flg = 1'b0;
        w_dbz = 1'b0;
        case (select)
            OP_ADD: {w_flg, w_res} = sat_add({1'b0, in_a} + {1'b0, in_b});
            OP_SUB: {w_flg, w_res} = sat_sub({1'b0, in_a} - {1'b0, in_b});
            OP_DIV: begin
                w_res = '1;
                w_dbz = 1'b1;
            end
            OP_AND: w_res = in_a & in_b;
            OP_OR:  w_res = in_a | in_b;
            OP_XOR: w_res = in_a ^ in_b;
            OP_NOT: w_res = ~in_a;
            default: w_res = '0;
        endcase
    end

    // MUL: r_p = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

    // DIV: r_p = {remainder, dividend bits shifting out / quotient bits shifting in}.
    assign w_rem_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_trial[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_out   <= '0;
            r_flag  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_cnt <= '0;
                        if (select == OP_MUL) begin
                            r_p     <= {{WIDTH{1'b0}}, in_b};
                            r_state <= S_MUL;
                        end else if (select == OP_DIV && in_b != '0) begin
                            r_p     <= {{WIDTH{1'b0}}, in_a};
                            r_state <= S_DIV;
                        end else begin
                            r_out   <= w_res;
                            r_flag  <= w_flg;
                            r_dbz   <= w_dbz;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_p   <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        {r_flag, r_out} <= sat_mul(w_mul_next);
                        r_dbz           <= 1'b0;
                        r_state         <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_p   <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out   <= w_div_next[WIDTH-1:0];
                        r_flag  <= 1'b0;
                        r_dbz   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign flag      = r_flag;
    assign dbz       = r_dbz;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): cycle-level reference model plus directed vectors with literal expectations.
module tb_seq_alu;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   select;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         flag;
    logic         dbz;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .select(select),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flag(flag), .dbz(dbz)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic [W-1:0] o;
        logic         f;
        logic         d;
    } res_t;

`ifdef ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Plain-arithmetic statement of each operation's result.
    function automatic res_t model_op(input int a, input int b, input int s);
        res_t r;
        int   t;
        r = '0;
        case (s)
            0: begin t = a + b; r.f = (t > MAXV); r.o = W'(t & MAXV); if (SAT && r.f) r.o = W'(MAXV); end
            1: begin r.f = (b > a); r.o = W'((a - b + MAXV + 1) & MAXV); if (SAT && r.f) r.o = '0; end
            2: begin t = a * b; r.f = (t > MAXV); r.o = W'(t & MAXV); if (SAT && r.f) r.o = W'(MAXV); end
            3: begin
                if (b == 0) begin r.o = W'(MAXV); r.d = 1'b1; end
                else r.o = W'(a / b);
            end
            4: r.o = W'(a & b);
            5: r.o = W'(a | b);
            6: r.o = W'(a ^ b);
            default: r.o = W'(~a & MAXV);
        endcase
        return r;
    endfunction

    // Cycle-level model: pending result, remaining latency, presented result.
    logic m_ready, m_valid;
    int   m_wait;
    res_t m_res, p_res;

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_wait  <= 0;
            m_res   <= '0;
            p_res   <= '0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_ready <= 1'b1;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_res   <= p_res;
            end
        end else if (in_valid) begin
            m_ready <= 1'b0;
            if (select == 3'd2 || (select == 3'd3 && in_b != '0)) begin
                m_wait <= W;
                p_res  <= model_op(int'(in_a), int'(in_b), int'(select));
            end else begin
                m_valid <= 1'b1;
                m_res   <= model_op(int'(in_a), int'(in_b), int'(select));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready",  32'(in_ready),  32'(m_ready));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cyc_out",       32'(out),       32'(m_res.o));
            chk("cyc_flag",      32'(flag),      32'(m_res.f));
            chk("cyc_dbz",       32'(dbz),       32'(m_res.d));
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                         input logic [W-1:0] eo, input logic ef, input logic ed,
                         input int elat, input int hold);
        int lat;
        @(negedge clk);
        in_a = a; in_b = b; select = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; select = ~s;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("out",  32'(out),  32'(eo));
        chk("flag", 32'(flag), 32'(ef));
        chk("dbz",  32'(dbz),  32'(ed));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_out",   32'(out),       32'(eo));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; select = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out",       32'(out),       32'd0);
        chk("rst_flag",      32'(flag),      32'd0);
        chk("rst_dbz",       32'(dbz),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'd200, 8'd100, 3'd0, SAT ? 8'd255 : 8'd44,  1'b1, 1'b0, 1, 0);
        do_op(8'd3,   8'd5,   3'd1, SAT ? 8'd0   : 8'd254, 1'b1, 1'b0, 1, 0);
        do_op(8'd9,   8'd4,   3'd1, 8'd5,   1'b0, 1'b0, 1, 0);
        do_op(8'd20,  8'd13,  3'd2, SAT ? 8'd255 : 8'd4,   1'b1, 1'b0, 9, 0);
        do_op(8'd15,  8'd15,  3'd2, 8'd225, 1'b0, 1'b0, 9, 0);
        do_op(8'd200, 8'd7,   3'd3, 8'd28,  1'b0, 1'b0, 9, 0);
        do_op(8'd5,   8'd0,   3'd3, 8'd255, 1'b0, 1'b1, 1, 0);
        do_op(8'hF0,  8'h3C,  3'd6, 8'hCC,  1'b0, 1'b0, 1, 5);
        do_op(8'hF0,  8'h3C,  3'd4, 8'h30,  1'b0, 1'b0, 1, 0);
        do_op(8'hF0,  8'h3C,  3'd5, 8'hFC,  1'b0, 1'b0, 1, 0);
        do_op(8'h5A,  8'h00,  3'd7, 8'hA5,  1'b0, 1'b0, 1, 0);
        do_op(8'd255, 8'd1,   3'd3, 8'd255, 1'b0, 1'b0, 9, 0);

        // out_ready while idle must not disturb anything.
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;

        // Reset three steps into a long multiply.
        @(negedge clk);
        in_a = 8'd255; in_b = 8'd255; select = 3'd2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out",       32'(out),       32'd0);
        chk("mrst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op(8'd1, 8'd1, 3'd0, 8'd2, 1'b0, 1'b0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
